// File: rtl/venus_exec_pkg.sv
// Shared types and helpers for the exec-stage writeback slice.
//   W_OPR      : operand/result width
//   W_REG      : register address width
//   wb_entry_t : buffered result {data, dst, wen}
//   flags_t    : {z, n, p} condition flags
//   calc_flags : zero / msb / odd-parity of a result
package venus_exec_pkg;

  localparam int unsigned W_OPR = 32;
  localparam int unsigned W_REG = 5;

  typedef struct packed {
    logic [W_OPR-1:0] data;
    logic [W_REG-1:0] dst;
    logic             wen;
  } wb_entry_t;

  typedef struct packed {
    logic z;
    logic n;
    logic p;
  } flags_t;

  // p is set for an odd number of ones
  function automatic flags_t calc_flags(input logic [W_OPR-1:0] data);
    flags_t f;
    f.z = (data == '0);
    f.n = data[W_OPR-1];
    f.p = ^data;
    return f;
  endfunction

endpackage

// File: rtl/exec_wb_fifo.sv
// In-order result buffer for exec_result_wb.
//   clk_i, rst_n_i : clock, async active-low reset
//   push_i, pop_i  : enqueue wdata_i / dequeue head (caller guards full/empty)
//   head_o         : oldest entry
//   full_o/empty_o : registered occupancy flags
//   mem_o, rd_ptr_o, count_o : raw storage view, only with EXEC_WB_FWD_EN
module exec_wb_fifo
  import venus_exec_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t wdata_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
`ifdef EXEC_WB_FWD_EN
  ,
  output wb_entry_t [DEPTH-1:0] mem_o,
  output logic [PTR_W-1:0]      rd_ptr_o,
  output logic [CNT_W-1:0]      count_o
`endif
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q;

  // Occupancy next state; simultaneous push+pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; flags track count_d
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

`ifdef EXEC_WB_FWD_EN
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
`endif

endmodule

// File: rtl/exec_result_wb.sv
// Exec-stage writeback: buffers exec results in an in-order FIFO and drains
// one per cycle into the register-file write port, tracking ZNP flags.
//   clk_i, rst_n_i                      : clock, async active-low reset
//   res_valid_i/res_ready_o             : result handshake (ready = !full, registered)
//   res_data_i, res_dst_i, res_wen_i    : result payload
//   rf_ready_i                          : rf write port available
//   rf_we_o, rf_addr_o, rf_data_o       : registered rf write
//   flags_o                             : {Z,N,P} of last retired result
//   busy_o                              : FIFO non-empty
// Optional EXEC_WB_FWD_EN adds combinational forwarding:
//   fwd_addr_i, fwd_hit_o, fwd_data_o
module exec_result_wb
  import venus_exec_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [W_OPR-1:0] res_data_i,
  input  logic [W_REG-1:0] res_dst_i,
  input  logic             res_wen_i,
  input  logic             rf_ready_i,
  output logic             rf_we_o,
  output logic [W_REG-1:0] rf_addr_o,
  output logic [W_OPR-1:0] rf_data_o,
  output logic [2:0]       flags_o,
  output logic             busy_o
`ifdef EXEC_WB_FWD_EN
  ,
  input  logic [W_REG-1:0] fwd_addr_i,
  output logic             fwd_hit_o,
  output logic [W_OPR-1:0] fwd_data_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        wdata, head;
  logic             full, empty;
  logic             push_c, pop_c;
  logic             rf_we_q, rf_we_d;
  logic [W_REG-1:0] rf_addr_q, rf_addr_d;
  logic [W_OPR-1:0] rf_data_q, rf_data_d;
  flags_t           flags_q, flags_d;

`ifdef EXEC_WB_FWD_EN
  wb_entry_t [DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]      fifo_rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
`endif

  assign wdata  = '{data: res_data_i, dst: res_dst_i, wen: res_wen_i};
  assign push_c = res_valid_i && !full;
  assign pop_c  = !empty && rf_ready_i;

  exec_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_i   (push_c),
    .pop_i    (pop_c),
    .wdata_i  (wdata),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty)
`ifdef EXEC_WB_FWD_EN
    ,
    .mem_o    (fifo_mem),
    .rd_ptr_o (fifo_rd_ptr),
    .count_o  (fifo_count)
`endif
  );

  // Retire stage: write strobe pulses for one cycle, addr/data/flags hold
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    flags_d   = flags_q;
    if (pop_c) begin
      rf_we_d   = head.wen;
      rf_addr_d = head.dst;
      rf_data_d = head.data;
      flags_d   = calc_flags(head.data);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      flags_q   <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      flags_q   <= flags_d;
    end
  end

  assign res_ready_o = !full;
  assign busy_o      = !empty;
  assign rf_we_o     = rf_we_q;
  assign rf_addr_o   = rf_addr_q;
  assign rf_data_o   = rf_data_q;
  assign flags_o     = flags_q;

`ifdef EXEC_WB_FWD_EN
  // Output stage first, then FIFO slots oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot       = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (rf_we_q && (rf_addr_q == fwd_addr_i)) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = rf_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = fifo_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < fifo_count) && fifo_mem[slot].wen &&
          (fifo_mem[slot].dst == fwd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = fifo_mem[slot].data;
      end
    end
  end
`endif

endmodule
